// File: rtl/alu_issuer_pkg.sv
// Shared definitions for the ALU command issuer, the attached alu and the bench:
// op-code constants and the issuer FSM state encoding.
package alu_issuer_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_issuer_if.sv
// Command and response handshakes of the issuer; master is the host side,
// slave is the issuer side.
interface alu_issuer_if #(
  parameter int WIDTH = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_use_acc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/alu_issuer_alu.sv
// Combinational ALU driven by the issuer: add (modulo 2^WIDTH), and, or;
// the reserved op returns zero.
module alu
  import alu_issuer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] result
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    result = '0;
    case (sel)
      OP_ADD:  result = a + b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_issuer.sv
// Sequential front-end for the combinational alu: registers one command,
// captures the ALU result a cycle later and holds it until the consumer takes it.
module alu_issuer
  import alu_issuer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issuer_if.slave      bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc,
  output logic             busy
);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic [WIDTH-1:0] result_q;

  assign accept = bus.cmd_valid && (state_q == IDLE);

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    busy          = (state_q != IDLE);
  end

  // Operand registers hold the last issued command outside EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= OP_ADD;
    end else if (accept) begin
      alu_a   <= bus.cmd_use_acc ? result_q : bus.cmd_a;
      alu_b   <= bus.cmd_b;
      alu_sel <= bus.cmd_op;
    end
  end

  // The response data and the accumulator are the same captured value, so one
  // register feeds both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                result_q <= '0;
    else if (state_q == EXEC) result_q <= alu_result;
  end

  assign bus.rsp_data = result_q;
  assign acc          = result_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer + alu: scoreboard of expected results,
// one task per scenario, outputs sampled on the falling edge.
module tb_alu_issuer;
  import alu_issuer_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_sel;
  logic [W-1:0] alu_result;
  logic [W-1:0] acc;
  logic         busy;

  alu_issuer_if #(.WIDTH(W)) bus ();

  alu_issuer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .acc        (acc),
    .busy       (busy)
  );

  alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .sel    (alu_sel),
    .result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           vectors    = 0;
  int           miscompares = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] model_acc = '0;

  function automatic logic [W-1:0] ref_alu(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      2'b00:   return sum[W-1:0];
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return '0;
    endcase
  endfunction

  // Drives one command starting at a falling edge; returns at the falling
  // edge inside EXEC after checking the registered ALU inputs.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic use_acc);
    logic [W-1:0] exp_a;
    int n;
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_use_acc = use_acc;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
      bus.cmd_valid = 1'b0;
      return;
    end
    exp_a = use_acc ? model_acc : a;
    sb.push_back(ref_alu(op, exp_a, b));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    vectors++;
    if ({bus.cmd_ready, bus.rsp_valid, busy, alu_a, alu_b, alu_sel} !==
        {1'b0, 1'b0, 1'b1, exp_a, b, op}) begin
      miscompares++;
      $display("FAIL exec_state: rdy/vld/busy=%b%b%b a=%h b=%h sel=%b, required 010 a=%h b=%h sel=%b",
               bus.cmd_ready, bus.rsp_valid, busy, alu_a, alu_b, alu_sel, exp_a, b, op);
    end
  endtask

  // Waits for rsp_valid (required on the very next falling edge) and checks
  // the response against the scoreboard; returns at that edge, still in RESP.
  task automatic collect(input string name);
    logic [W-1:0] exp;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!bus.rsp_valid || n != 0) begin
      miscompares++;
      $display("FAIL %s_rsp_latency: rsp_valid=%b after %0d extra cycles, required 1 after 0", name, bus.rsp_valid, n);
      if (!bus.rsp_valid) return;
    end
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s_scoreboard: response with no expected entry, rsp_data=%h", name, bus.rsp_data);
      return;
    end
    exp = sb.pop_front();
    if ({bus.rsp_data, acc} !== {exp, exp}) begin
      miscompares++;
      $display("FAIL %s_data: rsp_data=%h acc=%h, required %h %h", name, bus.rsp_data, acc, exp, exp);
    end
    model_acc = exp;
  endtask

  task automatic expect_idle(input string name);
    vectors++;
    if ({bus.cmd_ready, bus.rsp_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL %s_idle: rdy/vld/busy=%b%b%b, required 100", name, bus.cmd_ready, bus.rsp_valid, busy);
    end
  endtask

  task automatic expect_reset_state(input string name);
    vectors++;
    if ({bus.cmd_ready, bus.rsp_valid, busy, bus.rsp_data, acc, alu_a, alu_b, alu_sel} !==
        {1'b1, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}, {W{1'b0}}, {W{1'b0}}, 2'b00}) begin
      miscompares++;
      $display("FAIL %s: rdy/vld/busy=%b%b%b data=%h acc=%h a=%h b=%h sel=%b, required 100 and all zero",
               name, bus.cmd_ready, bus.rsp_valid, busy, bus.rsp_data, acc, alu_a, alu_b, alu_sel);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.cmd_use_acc = 1'b0; bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    expect_reset_state("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    expect_reset_state("reset_released");
  endtask

  task automatic test_ops();
    bus.rsp_ready = 1'b1;
    issue(OP_ADD, 4'd7, 4'd12, 1'b0);
    collect("add_wrap");
    @(negedge clk);
    expect_idle("add_wrap");
    vectors++;
    if ({alu_a, alu_b, alu_sel} !== {4'd7, 4'd12, OP_ADD}) begin
      miscompares++;
      $display("FAIL operand_hold: a=%h b=%h sel=%b, required 7 c 00", alu_a, alu_b, alu_sel);
    end
    issue(OP_AND, 4'hA, 4'h6, 1'b0);
    collect("and");
    @(negedge clk);
    issue(OP_OR, 4'hA, 4'h5, 1'b0);
    collect("or");
    @(negedge clk);
  endtask

  task automatic test_reserved();
    bus.rsp_ready = 1'b1;
    issue(OP_RSVD, 4'd5, 4'd3, 1'b0);
    collect("reserved");
    @(negedge clk);
    expect_idle("reserved");
  endtask

  task automatic test_acc_chain();
    bus.rsp_ready = 1'b1;
    issue(OP_ADD, 4'd1, 4'd2, 1'b0);
    collect("chain_add");
    @(negedge clk);
    issue(OP_ADD, 4'hF, 4'd4, 1'b1);
    collect("chain_acc_add");
    @(negedge clk);
    issue(OP_OR, 4'h0, 4'hC, 1'b1);
    collect("chain_acc_or");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(2'($urandom_range(0, 2)), 4'($urandom), 4'($urandom), 1'(i % 2));
      collect("b2b");
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    issue(OP_ADD, 4'd3, 4'd4, 1'b0);
    collect("bp");
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_OR; bus.cmd_a = 4'h9; bus.cmd_b = 4'h9;
      bus.cmd_use_acc = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.rsp_valid, bus.cmd_ready, busy, bus.rsp_data, alu_a, alu_b, alu_sel} !==
          {1'b1, 1'b0, 1'b1, 4'd7, 4'd3, 4'd4, OP_ADD}) begin
        miscompares++;
        $display("FAIL bp_hold: vld/rdy/busy=%b%b%b data=%h a=%h b=%h sel=%b, required 101 7 3 4 00",
                 bus.rsp_valid, bus.cmd_ready, busy, bus.rsp_data, alu_a, alu_b, alu_sel);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      expect_idle("bp_release");
    end
  endtask

  task automatic test_reset_exec();
    bus.rsp_ready = 1'b1;
    issue(OP_OR, 4'd1, 4'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_reset_state("reset_in_exec");
    sb.delete();
    model_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      expect_idle("after_exec_reset");
    end
  endtask

  task automatic test_reset_resp();
    bus.rsp_ready = 1'b0;
    issue(OP_ADD, 4'd5, 4'd6, 1'b0);
    collect("pre_reset_resp");
    rst_n = 1'b0;
    #1;
    expect_reset_state("reset_in_resp");
    sb.delete();
    model_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      expect_idle("after_resp_reset");
    end
    issue(OP_ADD, 4'h9, 4'd2, 1'b1);
    collect("acc_after_reset");
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ops();
    test_reserved();
    test_acc_chain();
    test_back_to_back();
    test_backpressure();
    test_reset_exec();
    test_reset_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
# alu_issuer

Sequential command front-end for the team's combinational `alu`. Accepts operation commands over a valid/ready handshake, drives the ALU operand and select lines from registers, captures the ALU result one cycle later and returns it over a second valid/ready handshake. Keeps an accumulator of the last result so operation chains run without the host re-supplying operands.

## Interface
- `WIDTH`, 4, operand/result width; must match the attached `alu`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: issuer can accept a command.
- `cmd_op` in 2: 00 add, 01 and, 10 or, 11 reserved.
- `cmd_a` in WIDTH: operand A.
- `cmd_b` in WIDTH: operand B.
- `cmd_use_acc` in 1: 1 = use accumulator instead of `cmd_a` as operand A.
- `alu_a` out WIDTH: registered operand A to the ALU.
- `alu_b` out WIDTH: registered operand B to the ALU.
- `alu_sel` out 2: registered select to the ALU.
- `alu_result` in WIDTH: combinational ALU result.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes result.
- `rsp_data` out WIDTH: captured result.
- `acc` out WIDTH: accumulator (last captured result).
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`: load `alu_a` ← (`cmd_use_acc` ? `acc` : `cmd_a`), `alu_b` ← `cmd_b`, `alu_sel` ← `cmd_op`; go EXEC.
- EXEC: `cmd_ready`=0. ALU settles combinationally. At end of cycle capture `alu_result` into `rsp_data` and `acc`; go RESP.
- RESP: `rsp_valid`=1, `rsp_data` held stable until `rsp_ready`=1 at a rising edge; then go IDLE.
- `cmd_ready` = (state == IDLE); never depends combinationally on `rsp_ready`.
- Arithmetic owned by the ALU: add is modulo 2^WIDTH (carry discarded); op 11 yields whatever the ALU returns (0 for the current `alu`); issuer forwards it unmodified and updates `acc`.
- `alu_a/alu_b/alu_sel` hold their last issued values outside EXEC.
- Reset (any time, including mid-EXEC or mid-RESP): state IDLE, all registered outputs 0, pending command and result discarded, `acc`=0.

## Timing
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `acc`=0, `alu_a`=0, `alu_b`=0, `alu_sel`=00, `busy`=0.
- Command accepted on edge N; ALU inputs valid after edge N; result captured on edge N+1; `rsp_valid`=1 after edge N+1.
- Minimum 3 cycles per command (accept, exec, respond with `rsp_ready` already high).
- `rsp_ready` low holds RESP indefinitely; `cmd_ready` stays 0 throughout.
- `cmd_use_acc` with back-to-back commands sees the `acc` value captured by the previous command.
- `cmd_valid` ignored outside IDLE; no command is lost because `cmd_ready`=0 there.

## Structure
- Shared package: op-code constants `OP_ADD`=2'b00, `OP_AND`=2'b01, `OP_OR`=2'b10, `OP_RSVD`=2'b11; FSM state encoding (IDLE/EXEC/RESP). Used by issuer, `alu`, and bench.
- No sub-module inside the issuer; `alu` is instantiated beside it at the next level up (and in the bench).

## Test plan
- Reset then add: `cmd_a`=7, `cmd_b`=12, op 00 -> `rsp_data`=3 (wrap), `rsp_valid` one edge after EXEC, `acc`=3.
- AND: `cmd_a`=0xA, `cmd_b`=0x6, op 01 -> `rsp_data`=0x2; OR: 0xA | 0x5, op 10 -> 0xF.
- Accumulator chain: add 1+2 -> 3; then `cmd_use_acc`=1, `cmd_b`=4, add -> 7; then `cmd_use_acc`=1, `cmd_b`=0xC, or -> 0xF.
- Backpressure: hold `rsp_ready`=0 for 5 cycles -> `rsp_valid`=1 and `rsp_data` stable, `cmd_ready`=0, extra `cmd_valid` ignored; release -> IDLE next edge.
- Reserved op 11 with a=5, b=3 -> `rsp_data`=0, `acc`=0.
- Assert `rst_n`=0 during EXEC and during RESP -> all outputs return to reset values immediately; no `rsp_valid` after release.
